// File: rtl/chn_adder_pipe.sv
// CH-lane signed add/sub/accumulate datapath with one registered output stage and valid/ready flow control.
// Optional macro CH_ADDER_SAT_EN: overflowing lanes saturate instead of wrapping.
module chn_adder_pipe #(
  parameter int CH = 8,
  parameter int DW = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [CH-1:0][DW-1:0] a_in,
  input  logic [CH-1:0][DW-1:0] b_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH-1:0][DW-1:0] z_out,
  output logic [CH-1:0]         ovf_out
);

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  op_e                   op_sel;
  logic                  fire_in;
  logic                  acc_wr;
  logic [CH-1:0][DW-1:0] acc;
  logic [CH-1:0][DW-1:0] lane_val;
  logic [CH-1:0]         lane_ovf;

  assign op_sel   = op_e'(op);
  assign in_ready = ~out_valid | out_ready;
  assign fire_in  = in_valid & in_ready;
  assign acc_wr   = fire_in & ((op_sel == OP_ACC) | (op_sel == OP_LOAD));

  // Each lane works one bit wider so the carry into the sign position is visible.
  for (genvar i = 0; i < CH; i++) begin : g_lane
    logic [DW:0]   a_ext;
    logic [DW:0]   b_ext;
    logic [DW:0]   acc_ext;
    logic [DW:0]   raw;
    logic [DW-1:0] val;

    assign a_ext   = {a_in[i][DW-1], a_in[i]};
    assign b_ext   = {b_in[i][DW-1], b_in[i]};
    assign acc_ext = {acc[i][DW-1], acc[i]};

    always_comb begin
      raw = a_ext;
      case (op_sel)
        OP_ADD:  raw = a_ext + b_ext;
        OP_SUB:  raw = a_ext - b_ext;
        OP_ACC:  raw = acc_ext + a_ext;
        default: raw = a_ext;
      endcase
    end

    assign lane_ovf[i] = raw[DW] ^ raw[DW-1];

`ifdef CH_ADDER_SAT_EN
    always_comb begin
      val = raw[DW-1:0];
      if (lane_ovf[i]) begin
        val = raw[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end
    end
`else
    assign val = raw[DW-1:0];
`endif

    assign lane_val[i] = val;
  end

  // A new result always replaces the held one; a drain without refill leaves a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      z_out     <= '0;
      ovf_out   <= '0;
    end else if (fire_in) begin
      out_valid <= 1'b1;
      z_out     <= lane_val;
      ovf_out   <= lane_ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_wr) begin
      acc <= lane_val;
    end
  end

endmodule

// File: tb/tb_chn_adder_pipe.sv
// Self-checking bench for chn_adder_pipe: directed test-plan cases plus a scoreboarded random stream.
`timescale 1ns/1ps
module tb_chn_adder_pipe;
  localparam int CH   = 8;
  localparam int DW   = 8;
  localparam int MAXV = (1 << (DW - 1)) - 1;
  localparam int MINV = -(1 << (DW - 1));

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef logic [CH-1:0][DW-1:0] vec_t;
  typedef struct {
    vec_t          z;
    logic [CH-1:0] ovf;
  } exp_t;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [1:0]    op        = 2'b00;
  vec_t          a_in      = '0;
  vec_t          b_in      = '0;
  logic          in_ready;
  logic          out_valid;
  vec_t          z_out;
  logic [CH-1:0] ovf_out;

  exp_t          sb_q[$];
  logic [DW-1:0] m_acc [CH];
  int            checks = 0;
  int            errors = 0;
  int            sent   = 0;
  vec_t          held;

  chn_adder_pipe #(.CH(CH), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z_out     (z_out),
    .ovf_out   (ovf_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] lv(input int v);
    logic [DW-1:0] t;
    t = DW'(v);
    return 64'(t);
  endfunction

  function automatic vec_t lanes(input int v0, input int v1);
    vec_t v;
    v    = '0;
    v[0] = DW'(v0);
    v[1] = DW'(v1);
    return v;
  endfunction

  // Reference model in plain integer arithmetic; also advances the modelled accumulators.
  function automatic exp_t modelStep(input logic [1:0] o, input vec_t a, input vec_t b);
    exp_t        e;
    int          ai, bi, ci, r;
    logic [31:0] rv;
    for (int l = 0; l < CH; l++) begin
      ai = $signed(a[l]);
      bi = $signed(b[l]);
      ci = $signed(m_acc[l]);
      case (o)
        OP_ADD:  r = ai + bi;
        OP_SUB:  r = ai - bi;
        OP_ACC:  r = ci + ai;
        default: r = ai;
      endcase
      e.ovf[l] = (r > MAXV) || (r < MINV);
`ifdef CH_ADDER_SAT_EN
      if (r > MAXV) r = MAXV;
      else if (r < MINV) r = MINV;
`endif
      rv     = r;
      e.z[l] = rv[DW-1:0];
      if (o == OP_ACC || o == OP_LOAD) m_acc[l] = e.z[l];
    end
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
      for (int l = 0; l < CH; l++) m_acc[l] = '0;
    end else begin
      if (out_valid && out_ready) begin
        checkOutput("sb_avail", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          checkOutput("sb_z", 64'(z_out), 64'(e.z));
          checkOutput("sb_ovf", 64'(ovf_out), 64'(e.ovf));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(modelStep(op, a_in, b_in));
    end
  end

  task automatic applyStimulus(input logic [1:0] o, input vec_t a, input vec_t b);
    logic accepted;
    accepted = 1'b0;
    op       = o;
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("accept", 64'(accepted), 64'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #2;
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_z", 64'(z_out), 64'd0);
    checkOutput("rst_ovf", 64'(ovf_out), 64'd0);
    checkOutput("rst_ready", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Reset mid-stream with a result pending and acc loaded
    applyStimulus(OP_LOAD, lanes(55, -9), '0);
    out_ready = 1'b0;
    checkOutput("pre_rst_z0", 64'(z_out[0]), lv(55));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_z", 64'(z_out), 64'd0);
    checkOutput("mid_rst_ovf", 64'(ovf_out), 64'd0);
    checkOutput("mid_rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(OP_ACC, lanes(5, 0), '0);
    checkOutput("acc_after_rst", 64'(z_out[0]), lv(5));

    applyStimulus(OP_ADD, lanes(100, -5), lanes(27, 3));
    checkOutput("add_z0", 64'(z_out[0]), lv(127));
    checkOutput("add_z1", 64'(z_out[1]), lv(-2));
    checkOutput("add_ovf", 64'(ovf_out), 64'd0);
    checkOutput("add_valid", 64'(out_valid), 64'd1);

    applyStimulus(OP_ADD, lanes(100, 0), lanes(50, 0));
`ifdef CH_ADDER_SAT_EN
    checkOutput("ovf_add_z0", 64'(z_out[0]), lv(127));
`else
    checkOutput("ovf_add_z0", 64'(z_out[0]), lv(-106));
`endif
    checkOutput("ovf_add_flag", 64'(ovf_out), 64'h01);
    applyStimulus(OP_SUB, lanes(0, -128), lanes(0, 1));
`ifdef CH_ADDER_SAT_EN
    checkOutput("ovf_sub_z1", 64'(z_out[1]), lv(-128));
`else
    checkOutput("ovf_sub_z1", 64'(z_out[1]), lv(127));
`endif
    checkOutput("ovf_sub_flag", 64'(ovf_out), 64'h02);

    applyStimulus(OP_LOAD, lanes(10, 0), '0);
    checkOutput("load_z0", 64'(z_out[0]), lv(10));
    applyStimulus(OP_ACC, lanes(20, 0), '0);
    checkOutput("acc1_z0", 64'(z_out[0]), lv(30));
    applyStimulus(OP_ACC, lanes(-5, 0), '0);
    checkOutput("acc2_z0", 64'(z_out[0]), lv(25));
    checkOutput("acc2_ovf", 64'(ovf_out), 64'd0);
    applyStimulus(OP_ACC, lanes(120, 0), '0);
`ifdef CH_ADDER_SAT_EN
    checkOutput("acc3_z0", 64'(z_out[0]), lv(127));
`else
    checkOutput("acc3_z0", 64'(z_out[0]), lv(-111));
`endif
    checkOutput("acc3_ovf", 64'(ovf_out), 64'h01);

    // Backpressure: a pending ACC must not touch acc while stalled
    for (int l = 0; l < CH; l++) held[l] = DW'(7);
    applyStimulus(OP_LOAD, held, '0);
    out_ready = 1'b0;
    op        = OP_ACC;
    for (int l = 0; l < CH; l++) a_in[l] = DW'(1);
    in_valid  = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checkOutput("bp_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_z", 64'(z_out), 64'(held));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp_after_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_after_z0", 64'(z_out[0]), lv(8));

    // Random streaming with random backpressure
    for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      op        = 2'($urandom_range(0, 3));
      for (int l = 0; l < CH; l++) begin
        a_in[l] = DW'($urandom);
        b_in[l] = DW'($urandom);
      end
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rand_sent", 64'(sent), 64'd1000);
    checkOutput("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/chn_adder_pipe.md
# chn_adder_pipe

Parametrised, pipelined N-channel signed adder/accumulator for the FDT datapath, the successor to the fixed 8-channel combinational adder. It processes CH lanes of DW-bit two's-complement operands per transaction through one registered stage with a valid/ready handshake. A per-transaction opcode selects add, subtract, accumulate or accumulator-load. Every lane reports overflow, and wrap-around or saturating arithmetic is selected at compile time.

## Interface
- CH, 8, number of independent lanes (≥1)
- DW, 8, lane width in bits, signed two's complement (≥2)

- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block accepts the input transaction
- op  in  2  opcode, sampled with the input: 00 ADD, 01 SUB, 10 ACC, 11 LOAD
- a_in  in  CH×DW  packed lane operands A; lane i is a_in[i]
- b_in  in  CH×DW  packed lane operands B; ignored for ACC and LOAD
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- z_out  out  CH×DW  packed lane results
- ovf_out  out  CH  per-lane overflow flag aligned with z_out

## Operation
- Input handshake (fire_in) occurs when in_valid and in_ready are both high. Output handshake (fire_out) occurs when out_valid and out_ready are both high.
- Per lane i, the raw result is computed at DW+1 bits, with operands sign-extended:
  - ADD: A+B
  - SUB: A−B
  - ACC: acc[i]+A
  - LOAD: A. LOAD never overflows.
- A lane overflows when the top two bits of the raw result differ.
- The final lane value depends on overflow:
  - No overflow: the low DW bits of the raw result.
  - Overflow: see Configuration.
- Accumulator update:
  - acc[i] is a DW-bit register per lane.
  - On fire_in with op ACC or LOAD, acc[i] takes the final lane value.
  - ADD and SUB leave acc unchanged.
  - acc has no reset other than rst_n and LOAD.
- Output stage:
  - On fire_in, z_out, ovf_out and out_valid←1 are registered.
  - If fire_out occurs without fire_in, out_valid←0 and z_out/ovf_out hold their last values.
- in_ready = ~out_valid | out_ready. This is combinational, which gives full throughput of one transaction per cycle.
- Reset values: out_valid=0, z_out=0, ovf_out=0, acc=0. in_ready is therefore 1 during and after reset.

## Timing
- Latency is 1 cycle. Inputs accepted at edge k appear on z_out/out_valid directly after edge k.
- Simultaneous fire_in and fire_out: the output register is replaced with the new result and out_valid stays 1. There is no bubble.
- Back-to-back ACC: each accumulate uses the acc value produced by the previous accepted ACC or LOAD. No hazard stall is allowed.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0. z_out, ovf_out and out_valid stay stable, and acc does not change.
- in_valid may drop without being accepted. a_in, b_in and op are only sampled on fire_in.
- rst_n assertion mid-stream immediately clears out_valid, the outputs and acc. Any in-flight result is discarded.
- No combinational path from a_in, b_in or op to any output.

## Configuration
- CH_ADDER_SAT_EN defined: an overflowing lane clamps.
  - Positive overflow gives 2^(DW−1)−1.
  - Negative overflow gives −2^(DW−1).
  - The clamped value is also what ACC/LOAD store into acc.
- CH_ADDER_SAT_EN undefined: an overflowing lane wraps to the low DW bits of the raw result.
- ovf_out reports overflow identically in both builds.

## Test plan
- Reset and ADD (DW=8, CH=8): assert rst_n=0 mid-stream, then release and send ADD with lane0 a=100, b=27 and lane1 a=−5, b=3.
  - During reset: all outputs are 0 and in_ready=1.
  - After the ADD: the next cycle shows z0=127, z1=−2, ovf=0 and out_valid=1.
- Overflow with lane0 a=100, b=50 (ADD) and lane1 a=−128, b=1 (SUB):
  - SAT build: z0=127 and z1=−128, with ovf0=ovf1=1.
  - Non-SAT build: z0=−106 and z1=127, with ovf0=ovf1=1.
- Accumulate: send LOAD a=10, then ACC a=20, ACC a=−5 and ACC a=120 on consecutive cycles with out_ready=1.
  - Results are 10, 30 and 25, each with ovf=0.
  - The final ACC gives 127 with ovf=1 in the SAT build, or −111 with ovf=1 in the non-SAT build.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1.
  - in_ready stays 0, and z_out and acc stay stable.
  - When out_ready rises, the next input is accepted in that same cycle and out_valid stays 1 continuously.
- Random streaming: randomise in_valid and out_ready at 50% with 1000 transactions across all ops.
  - The scoreboard, which models acc per lane, shows no drops, no duplicates and correct order and values.
